fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000, SHALL be the instruction word driven on IF_ID_inst for a bubble.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 hazard_stall  in  1  SHALL be the load-use stall from the hazard unit; it freezes the PC and the IF/ID outputs.
REQ-006 MemStall  in  1  SHALL be the global data-memory stall; it freezes the PC and the IF/ID outputs.
REQ-007 branch_taken  in  1  SHALL be the single-cycle redirect pulse; it is never asserted while MemStall=1.
REQ-008 branch_target  in  32  SHALL be the redirect address, valid with branch_taken.
REQ-009 im_req  out  1  SHALL be the instruction-memory request.
REQ-010 im_addr  out  32  SHALL be the word address of the request.
REQ-011 im_gnt  in  1  SHALL mean the request is accepted this cycle.
REQ-012 im_rvalid  in  1  SHALL mean im_rdata holds the response.
REQ-013 im_rdata  in  32  SHALL be the instruction word.
REQ-014 IF_ID_valid  out  1  SHALL be 1 when IF_ID_pc and IF_ID_inst hold a real instruction.
REQ-015 IF_ID_pc  out  32  SHALL be the PC of the instruction in IF/ID.
REQ-016 IF_ID_inst  out  32  SHALL be the instruction in IF/ID (`RegAddrBus fields are decoded downstream).

Function
REQ-017 stall SHALL be defined as hazard_stall | MemStall.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, HOLD; the state after reset SHALL be IDLE.
REQ-019 IDLE SHALL go to REQ on the next cycle.
REQ-020 In REQ: im_req=1 and im_addr=pc; im_gnt=1 SHALL go to WAIT and set pc <= pc+4.
REQ-021 In WAIT: im_rvalid with stall=0 SHALL load IF/ID directly (bypass) and go to REQ.
REQ-022 In WAIT: im_rvalid with stall=1 SHALL capture {pc, inst} into the 1-entry buffer and go to HOLD.
REQ-023 In HOLD: when stall=0, the buffer SHALL drain into IF/ID, the buffer SHALL clear, and the FSM SHALL go to REQ.
REQ-024 At most one request SHALL be outstanding; im_req SHALL be 0 in WAIT and HOLD.
REQ-025 Latency: im_rvalid in cycle t SHALL give IF_ID_valid=1 in cycle t+1 when stall=0 in cycle t.
REQ-026 When stall=0 and no instruction is available, IF/ID SHALL load a bubble: valid=0, inst=NOP_INST, pc unchanged.
REQ-027 When stall=1, IF_ID_* SHALL hold their values exactly.
REQ-028 branch_taken SHALL override hazard_stall and take effect in the same cycle:
  - pc <= branch_target
  - IF/ID <= bubble
  - buffer cleared
  - FSM -> REQ
REQ-029 branch_taken in WAIT, or in REQ together with im_gnt=1, SHALL set a drop flag; the next im_rvalid SHALL be discarded and clear the flag. The FSM SHALL stay in WAIT until that response arrives, then go to REQ.
REQ-030 branch_taken coincident with im_rvalid SHALL discard that response.
REQ-031 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-032 im_addr SHALL be driven from a register, with no combinational path from stall inputs.

Reset
REQ-033 While rst=0:
  - pc=RESET_PC, FSM=IDLE
  - buffer empty, drop flag 0
  - im_req=0, IF_ID_valid=0, IF_ID_pc=0, IF_ID_inst=NOP_INST
REQ-034 Reset asserted mid-transaction SHALL abandon the outstanding request; a response arriving after deassertion SHALL be ignored until the first grant.

Structure
REQ-035 The fetch state enum, NOP_INST and RESET_PC defaults SHALL live in the shared cpu package.
REQ-036 The 1-entry holding buffer SHALL be a sub-module, fetch_buffer (load, drain, clear, valid, pc, inst).

Verification
REQ-037 Reset release, im_gnt=1 immediately, rvalid 1 cycle later with 32'h2002_0005 -> im_addr=0 then 4; IF_ID_inst=32'h2002_0005, pc=0, valid=1 one cycle after rvalid.
REQ-038 hazard_stall=1 for 2 cycles while a response returns -> instruction held in the buffer; IF/ID unchanged; instruction appears in IF/ID the cycle after stall drops; no duplicate or lost fetch.
REQ-039 branch_taken with target 32'h0000_0100 while in WAIT -> in-flight response discarded; IF_ID_valid=0; next im_addr=32'h100.
REQ-040 MemStall=1 for 5 cycles with im_gnt held 0 -> im_req stays asserted, im_addr stable, IF_ID_* constant.
REQ-041 rst pulsed low during WAIT, then a stale rvalid -> ignored; first fetch at RESET_PC.
REQ-042 pc=32'hFFFF_FFFC, granted -> next im_addr=32'h0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and reset defaults
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry holding slot for a response that arrives during a stall
module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);
  // clear and drain empty the slot; load captures a stalled response
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      inst  <= in_inst;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with stall buffer and branch redirect
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        MemStall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        IF_ID_valid,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst
);
  fetch_state_t state, state_next;
  logic [31:0] pc, pc_next, fetch_pc;
  logic        drop, drop_next;
  logic        stall, grant, resp, take, drain;
  logic        buf_valid;
  logic [31:0] buf_pc, buf_inst;

  assign stall   = hazard_stall | MemStall;
  assign im_req  = state == REQ;
  assign im_addr = pc;
  assign grant   = im_req && im_gnt;
  assign resp    = state == WAIT && im_rvalid;
  assign take    = resp && !drop && !branch_taken;
  assign drain   = state == HOLD && buf_valid && !stall && !branch_taken;

  // next state, pc and drop flag; a redirect wins over any stall
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = REQ;
      REQ:     state_next = im_gnt ? WAIT : REQ;
      WAIT:    state_next = !im_rvalid ? WAIT : (branch_taken || drop || !stall) ? REQ : HOLD;
      HOLD:    state_next = (branch_taken || !stall) ? REQ : HOLD;
      default: state_next = IDLE;
    endcase
    pc_next   = branch_taken ? branch_target : grant ? pc + 32'd4 : pc;
    drop_next = resp ? 1'b0 : (branch_taken && (state == WAIT || grant)) ? 1'b1 : drop;
  end

  // control registers; fetch_pc remembers the address of the request in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      fetch_pc <= grant ? pc : fetch_pc;
      drop     <= drop_next;
    end

  fetch_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (take && stall),
    .drain   (drain),
    .clear   (branch_taken),
    .in_pc   (fetch_pc),
    .in_inst (im_rdata),
    .valid   (buf_valid),
    .pc      (buf_pc),
    .inst    (buf_inst)
  );

  // IF/ID register: frozen on stall, otherwise bypass, drain or bubble
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      IF_ID_valid <= 1'b0;
      IF_ID_pc    <= '0;
      IF_ID_inst  <= NOP_INST;
    end else if (branch_taken || !stall) begin
      IF_ID_valid <= take || drain;
      IF_ID_pc    <= take ? fetch_pc : drain ? buf_pc : IF_ID_pc;
      IF_ID_inst  <= take ? im_rdata : drain ? buf_inst : NOP_INST;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_stall, MemStall, branch_taken;
  logic [31:0] branch_target;
  logic        im_req, im_gnt, im_rvalid;
  logic [31:0] im_addr, im_rdata;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_pc, IF_ID_inst;
  int          checks = 0;
  int          failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .hazard_stall  (hazard_stall),
    .MemStall      (MemStall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .im_req        (im_req),
    .im_addr       (im_addr),
    .im_gnt        (im_gnt),
    .im_rvalid     (im_rvalid),
    .im_rdata      (im_rdata),
    .IF_ID_valid   (IF_ID_valid),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_inst    (IF_ID_inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    check({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
    check({tag, "_pc"}, IF_ID_pc, p);
    check({tag, "_inst"}, IF_ID_inst, i);
  endtask

  initial begin
    rst = 1'b0; hazard_stall = 0; MemStall = 0; branch_taken = 0; branch_target = '0;
    im_gnt = 0; im_rvalid = 0; im_rdata = '0;
    tick; tick;
    check("rst_req", {31'd0, im_req}, 32'd0);
    check("rst_addr", im_addr, 32'h0);
    ifid("rst", 1'b0, 32'h0, NOP);
    rst = 1'b1;
    tick;
    check("a_req", {31'd0, im_req}, 32'd1);
    check("a_addr0", im_addr, 32'h0);
    im_gnt = 1;
    tick;
    check("a_wait_req", {31'd0, im_req}, 32'd0);
    check("a_addr4", im_addr, 32'h4);
    im_gnt = 0; im_rvalid = 1; im_rdata = 32'h2002_0005;
    tick;
    ifid("a_ifid", 1'b1, 32'h0, 32'h2002_0005);
    check("a_req2", {31'd0, im_req}, 32'd1);
    im_rvalid = 0;
    im_gnt = 1;
    tick;
    ifid("b_bubble", 1'b0, 32'h0, NOP);
    im_gnt = 0; im_rvalid = 1; im_rdata = 32'hAAAA_0001; hazard_stall = 1;
    tick;
    ifid("b_hold1", 1'b0, 32'h0, NOP);
    check("b_hold_req", {31'd0, im_req}, 32'd0);
    im_rvalid = 0;
    tick;
    ifid("b_hold2", 1'b0, 32'h0, NOP);
    hazard_stall = 0;
    tick;
    ifid("b_drain", 1'b1, 32'h4, 32'hAAAA_0001);
    check("b_addr8", im_addr, 32'h8);
    MemStall = 1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("c_ms_req", {31'd0, im_req}, 32'd1);
      check("c_ms_addr", im_addr, 32'h8);
      ifid("c_ms", 1'b1, 32'h4, 32'hAAAA_0001);
    end
    MemStall = 0;
    tick;
    ifid("c_after", 1'b0, 32'h4, NOP);
    im_gnt = 1;
    tick;
    im_gnt = 0; branch_taken = 1; branch_target = 32'h0000_0100;
    tick;
    check("d_br_req", {31'd0, im_req}, 32'd0);
    check("d_br_valid", {31'd0, IF_ID_valid}, 32'd0);
    branch_taken = 0; im_rvalid = 1; im_rdata = 32'hDEAD_BEEF;
    tick;
    ifid("d_drop", 1'b0, 32'h4, NOP);
    check("d_req", {31'd0, im_req}, 32'd1);
    check("d_addr100", im_addr, 32'h100);
    im_rvalid = 0; im_gnt = 1;
    tick;
    im_gnt = 0; im_rvalid = 1; im_rdata = 32'hBAD0_0001;
    branch_taken = 1; branch_target = 32'h0000_0200; hazard_stall = 1;
    tick;
    ifid("e_coinc", 1'b0, 32'h4, NOP);
    check("e_addr200", im_addr, 32'h200);
    check("e_req", {31'd0, im_req}, 32'd1);
    im_rvalid = 0; branch_taken = 0; hazard_stall = 0; im_gnt = 1;
    tick;
    im_gnt = 0; im_rvalid = 1; im_rdata = 32'h1234_5678;
    tick;
    ifid("e_fetch", 1'b1, 32'h200, 32'h1234_5678);
    im_rvalid = 0; branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    tick;
    check("f_addr_top", im_addr, 32'hFFFF_FFFC);
    branch_taken = 0; im_gnt = 1;
    tick;
    check("f_wrap", im_addr, 32'h0);
    im_gnt = 0; im_rvalid = 1; im_rdata = 32'h0000_0F0F;
    tick;
    ifid("f_ifid", 1'b1, 32'hFFFF_FFFC, 32'h0000_0F0F);
    im_rvalid = 0; im_gnt = 1;
    tick;
    im_gnt = 0;
    rst = 1'b0;
    #1;
    check("g_rst_req", {31'd0, im_req}, 32'd0);
    check("g_rst_addr", im_addr, 32'h0);
    ifid("g_rst", 1'b0, 32'h0, NOP);
    tick;
    rst = 1'b1; im_rvalid = 1; im_rdata = 32'h6666_6666;
    tick;
    ifid("g_stale1", 1'b0, 32'h0, NOP);
    check("g_req", {31'd0, im_req}, 32'd1);
    check("g_addr", im_addr, 32'h0);
    tick;
    ifid("g_stale2", 1'b0, 32'h0, NOP);
    im_rvalid = 0; im_gnt = 1;
    tick;
    im_gnt = 0; im_rvalid = 1; im_rdata = 32'h5555_0000;
    tick;
    ifid("g_fetch", 1'b1, 32'h0, 32'h5555_0000);
    im_rvalid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
